// File: rtl/exe_mem_pipe.sv
// EXE->MEM pipeline register: DEPTH elastic stages with valid/ready handshake,
// global flush, bubble-gated memory/write-back controls, forwarding taps and a
// saturating back-pressure counter.
module exe_mem_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         pc_in,
  input  logic [REG_AW-1:0]         dst_in,
  input  logic                      mem_read_in,
  input  logic                      mem_write_in,
  input  logic                      wb_en_in,
  input  logic [DATA_W-1:0]         alu_res_in,
  input  logic [DATA_W-1:0]         val_rm_in,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         pc_out,
  output logic [REG_AW-1:0]         dst_out,
  output logic [DATA_W-1:0]         alu_res_out,
  output logic [DATA_W-1:0]         val_rm_out,
  output logic                      mem_read_out,
  output logic                      mem_write_out,
  output logic                      wb_en_out,
  output logic [DEPTH-1:0]          fwd_valid,
  output logic [DEPTH*REG_AW-1:0]   fwd_dst,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned LAST = DEPTH - 1;

  // One EXE result bundle as it travels down the pipe.
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] dst;
    logic              mem_read;
    logic              mem_write;
    logic              wb_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
  } beat_t;

  beat_t            in_beat;
  beat_t            stage_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;

  beat_t            up_beat  [DEPTH];
  logic [DEPTH-1:0] up_valid;
  logic [DEPTH-1:0] rdy;

  assign in_beat = '{
    pc:        pc_in,
    dst:       dst_in,
    mem_read:  mem_read_in,
    mem_write: mem_write_in,
    wb_en:     wb_en_in,
    alu_res:   alu_res_in,
    val_rm:    val_rm_in
  };

  // Ready chain: a stage can load if it is empty or anything downstream frees
  // up; walked from the output back so no signal feeds itself.
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready;
    rdy = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      acc    = acc | ~valid_q[i];
      rdy[i] = acc;
    end
  end

  // Upstream source of each stage: inputs for stage 0, previous stage otherwise.
  always_comb begin
    up_valid    = '0;
    up_valid[0] = in_valid;
    for (int i = 0; i < int'(DEPTH); i++) begin
      up_beat[i] = in_beat;
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      up_valid[i] = valid_q[i-1];
      up_beat[i]  = stage_q[i-1];
    end
  end

  // Flush drops everything in flight and stalls nobody upstream.
  assign in_ready = flush | rdy[0];

  // Stage registers: load when ready, hold otherwise; flush clears valids only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (flush) begin
          valid_q[i] <= 1'b0;
        end else if (rdy[i]) begin
          valid_q[i] <= up_valid[i];
        end
        if (rdy[i]) begin
          stage_q[i] <= up_beat[i];
        end
      end
    end
  end

  // Saturating count of cycles where the MEM stage refused a valid beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (valid_q[LAST] && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Output stage; controls are masked so a bubble never looks like a load/store.
  assign out_valid     = valid_q[LAST];
  assign pc_out        = stage_q[LAST].pc;
  assign dst_out       = stage_q[LAST].dst;
  assign alu_res_out   = stage_q[LAST].alu_res;
  assign val_rm_out    = stage_q[LAST].val_rm;
  assign mem_read_out  = valid_q[LAST] & stage_q[LAST].mem_read;
  assign mem_write_out = valid_q[LAST] & stage_q[LAST].mem_write;
  assign wb_en_out     = valid_q[LAST] & stage_q[LAST].wb_en;

  // Forwarding taps straight off the stage registers.
  always_comb begin
    fwd_valid = '0;
    fwd_dst   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      fwd_valid[i]                = valid_q[i] & stage_q[i].wb_en;
      fwd_dst[i*REG_AW +: REG_AW] = stage_q[i].dst;
    end
  end

endmodule

// File: tb/tb_exe_mem_pipe.sv
// Scoreboard bench for exe_mem_pipe at DEPTH=3, CNT_W=4.
module tb_exe_mem_pipe;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       pc_in;
  logic [REG_AW-1:0]       dst_in;
  logic                    mem_read_in;
  logic                    mem_write_in;
  logic                    wb_en_in;
  logic [DATA_W-1:0]       alu_res_in;
  logic [DATA_W-1:0]       val_rm_in;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       pc_out;
  logic [REG_AW-1:0]       dst_out;
  logic [DATA_W-1:0]       alu_res_out;
  logic [DATA_W-1:0]       val_rm_out;
  logic                    mem_read_out;
  logic                    mem_write_out;
  logic                    wb_en_out;
  logic [DEPTH-1:0]        fwd_valid;
  logic [DEPTH*REG_AW-1:0] fwd_dst;
  logic [CNT_W-1:0]        stall_cnt;

  exe_mem_pipe #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .dst_in(dst_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .wb_en_in(wb_en_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .dst_out(dst_out),
    .alu_res_out(alu_res_out), .val_rm_out(val_rm_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .wb_en_out(wb_en_out),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] dst;
    logic              mr;
    logic              mw;
    logic              wb;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rm;
  } exp_beat_t;

  exp_beat_t   sbq[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int unsigned stall_exp = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] pc, input logic [REG_AW-1:0] dst,
                       input logic mr, input logic mw, input logic wb,
                       input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] rm);
    in_valid     = v;
    pc_in        = pc;
    dst_in       = dst;
    mem_read_in  = mr;
    mem_write_in = mw;
    wb_en_in     = wb;
    alu_res_in   = alu;
    val_rm_in    = rm;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // One clock: sample handshakes at negedge, update scoreboard, advance to posedge+1.
  task automatic cycle();
    exp_beat_t e;
    exp_beat_t b;
    @(negedge clk);
    if (!out_valid)
      check("bubble_ctrl", 64'({mem_read_out, mem_write_out, wb_en_out}), 64'(0));
    if (flush)
      check("flush_in_ready", 64'(in_ready), 64'(1));
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 64'(out_valid), 64'(0));
      end else begin
        e = sbq.pop_front();
        check("pc_out",      64'(pc_out),         64'(e.pc));
        check("dst_out",     64'(dst_out),        64'(e.dst));
        check("mem_read",    64'(mem_read_out),   64'(e.mr));
        check("mem_write",   64'(mem_write_out),  64'(e.mw));
        check("wb_en",       64'(wb_en_out),      64'(e.wb));
        check("alu_res",     64'(alu_res_out),    64'(e.alu));
        check("val_rm",      64'(val_rm_out),     64'(e.rm));
        check("fwd_top_vld", 64'(fwd_valid[DEPTH-1]), 64'(e.wb));
        check("fwd_top_dst", 64'(fwd_dst[(DEPTH-1)*REG_AW +: REG_AW]), 64'(e.dst));
      end
    end
    if (out_valid && !out_ready && stall_exp < CNT_MAX) stall_exp++;
    if (flush) begin
      sbq.delete();
    end else if (in_valid && in_ready) begin
      b.pc = pc_in;  b.dst = dst_in; b.mr = mem_read_in; b.mw = mem_write_in;
      b.wb = wb_en_in; b.alu = alu_res_in; b.rm = val_rm_in;
      sbq.push_back(b);
    end
    @(posedge clk);
    #1;
    check("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
  endtask

  task automatic fill3(input logic mw, input logic [DATA_W-1:0] base);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, base + DATA_W'(k * 4), REG_AW'(k + 1), 1'b0, mw, 1'b1,
            base + DATA_W'(k), DATA_W'(k + 16));
      cycle();
    end
    idle();
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_pc_out",    64'(pc_out),    64'(0));
    check("rst_alu_out",   64'(alu_res_out), 64'(0));
    check("rst_fwd_valid", 64'(fwd_valid), 64'(0));
    check("rst_fwd_dst",   64'(fwd_dst),   64'(0));
    check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    rst = 1'b1;

    // Single beat: DEPTH cycles of latency, taps walk through the stages.
    out_ready = 1'b1;
    drive(1'b1, 32'h100, 4'd3, 1'b0, 1'b0, 1'b1, 32'hDEAD, 32'h55);
    cycle();
    idle();
    check("lat_fwd_s0",  64'(fwd_valid), 64'(3'b001));
    check("lat_dst_s0",  64'(fwd_dst[3:0]), 64'(3));
    check("lat_ov_1",    64'(out_valid), 64'(0));
    cycle();
    check("lat_fwd_s1",  64'(fwd_valid), 64'(3'b010));
    check("lat_dst_s1",  64'(fwd_dst[7:4]), 64'(3));
    check("lat_ov_2",    64'(out_valid), 64'(0));
    cycle();
    check("lat_ov_3",    64'(out_valid), 64'(1));
    check("lat_pc",      64'(pc_out), 64'(32'h100));
    check("lat_dst",     64'(dst_out), 64'(3));
    check("lat_alu",     64'(alu_res_out), 64'(32'hDEAD));
    check("lat_wb",      64'(wb_en_out), 64'(1));
    check("lat_fwd_s2",  64'(fwd_valid), 64'(3'b100));
    cycle();
    check("lat_ov_4",    64'(out_valid), 64'(0));

    // Back-to-back stream: one beat per cycle, no gaps.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, DATA_W'(k * 4), REG_AW'(k), 1'b1, 1'b0, 1'b0, DATA_W'(k + 7), DATA_W'(k));
      cycle();
      check("strm_ov", 64'(out_valid), 64'(k >= 2));
      if (k >= 2) check("strm_pc", 64'(pc_out), 64'((k - 2) * 4));
    end
    idle();
    cycle();
    check("strm_pc8",  64'(pc_out), 64'(8));
    check("strm_ov5",  64'(out_valid), 64'(1));
    cycle();
    check("strm_pc12", 64'(pc_out), 64'(12));
    cycle();
    check("strm_ov_end", 64'(out_valid), 64'(0));

    // Full pipe under back-pressure holds and refuses input.
    fill3(1'b0, 32'h2000);
    check("stall_full_ov", 64'(out_valid), 64'(1));
    drive(1'b1, 32'h3000, 4'd9, 1'b1, 1'b0, 1'b1, 32'h77, 32'h88);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_in_ready", 64'(in_ready), 64'(0));
      cycle();
      check("stall_hold_pc", 64'(pc_out), 64'(32'h2000));
    end
    check("stall_cnt5", 64'(stall_cnt), 64'(5));
    out_ready = 1'b1;
    cycle();
    idle();
    repeat (4) cycle();
    check("stall_drained", 64'(sbq.size()), 64'(0));

    // Flush with the output stalled: counter still ticks, offered beat dropped.
    fill3(1'b1, 32'h4000);
    drive(1'b1, 32'hBAD, 4'd5, 1'b0, 1'b1, 1'b1, 32'hBAD, 32'hBAD);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    idle();
    check("flush_ov",    64'(out_valid), 64'(0));
    check("flush_mw",    64'(mem_write_out), 64'(0));
    check("flush_fwd",   64'(fwd_valid), 64'(0));
    check("flush_stall", 64'(stall_cnt), 64'(6));
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("flush_empty", 64'(out_valid), 64'(0));
    end

    // Flush coinciding with an output handshake: that beat is consumed.
    fill3(1'b0, 32'h5000);
    out_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_hs_ov", 64'(out_valid), 64'(0));
    repeat (3) cycle();

    // Long stall saturates the counter.
    fill3(1'b0, 32'h6000);
    repeat (20) cycle();
    check("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
    out_ready = 1'b1;
    repeat (4) cycle();
    check("sat_drained", 64'(sbq.size()), 64'(0));

    // Random traffic with occasional flushes.
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, REG_AW'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom, $urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    repeat (6) cycle();
    check("rand_drained", 64'(sbq.size()), 64'(0));

    // Asynchronous reset between edges while the pipe holds beats.
    fill3(1'b1, 32'h7000);
    #3;
    rst = 1'b0;
    #1;
    check("arst_ov",    64'(out_valid), 64'(0));
    check("arst_pc",    64'(pc_out), 64'(0));
    check("arst_alu",   64'(alu_res_out), 64'(0));
    check("arst_rm",    64'(val_rm_out), 64'(0));
    check("arst_mw",    64'(mem_write_out), 64'(0));
    check("arst_fwd",   64'(fwd_valid), 64'(0));
    check("arst_fdst",  64'(fwd_dst), 64'(0));
    check("arst_stall", 64'(stall_cnt), 64'(0));
    sbq.delete();
    stall_exp = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("arst_in_ready", 64'(in_ready), 64'(1));
    check("arst_empty",    64'(out_valid), 64'(0));
    out_ready = 1'b1;
    drive(1'b1, 32'h8000, 4'd2, 1'b1, 1'b0, 1'b1, 32'h1, 32'h2);
    cycle();
    idle();
    repeat (4) cycle();
    check("final_empty", 64'(sbq.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
